// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Main-memory slave for a cache controller's refill / write-back port.
//   Serves one 64-bit line request at a time from an internal word array
//   after a fixed LATENCY, and completes with a one-cycle MM_ready pulse,
//   then waits for the request to drop (4-phase handshake) before re-arming.
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   mem_read/write    : request strobes, held by the master until MM_ready
//   mem_addr          : line address; word index = addr[OFFSET_BITS +: DEPTH_LOG2]
//   mem_wdata         : write data, sampled at acceptance
//   mem_rdata         : read data, loaded on read completion and held
//   MM_ready          : one-cycle completion pulse
//   busy              : high whenever the FSM is not idle
//   protocol_err      : one-cycle pulse after accepting read & write together
//   rd_count/wr_count : wrapping completed-transaction counters
module main_memory_responder #(
   parameter int LATENCY     = 4,
   parameter int DEPTH_LOG2  = 10,
   parameter int OFFSET_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [63:0] mem_wdata,
   output logic [63:0] mem_rdata,
   output logic        MM_ready,
   output logic        busy,
   output logic        protocol_err,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   logic [63:0] mem [DEPTH];

   logic [1:0]            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  op_wr_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [63:0]           wdata_q;
   logic [63:0]           rdata_q;
   logic                  ready_q, perr_q, busy_q;
   logic [15:0]           rd_cnt_q, wr_cnt_q;

   logic accept, commit;

   // Offset and upper tag bits are intentionally ignored (address aliasing).
   logic unused_addr;
   assign unused_addr = ^mem_addr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: if (mem_read || mem_write) begin
            accept  = 1'b1;
            state_d = WAIT;
            cnt_d   = LAT_M1;
         end
         WAIT: if (cnt_q == 8'd0) begin
            // commit happens on the edge that enters RESP
            commit  = 1'b1;
            state_d = RESP;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
         RESP: state_d = HOLD;
         HOLD: if (!mem_read && !mem_write) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         op_wr_q  <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 64'd0;
         rdata_q  <= 64'd0;
         ready_q  <= 1'b0;
         perr_q   <= 1'b0;
         busy_q   <= 1'b0;
         rd_cnt_q <= 16'd0;
         wr_cnt_q <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= commit;
         perr_q  <= accept && mem_read && mem_write;
         busy_q  <= (state_d != IDLE);
         if (accept) begin
            // write wins when both strobes are high
            op_wr_q <= mem_write;
            idx_q   <= mem_addr[OFFSET_BITS +: DEPTH_LOG2];
            wdata_q <= mem_wdata;
         end
         if (commit) begin
            if (op_wr_q) begin
               wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
               rd_cnt_q <= rd_cnt_q + 16'd1;
               rdata_q  <= mem[idx_q];
            end
         end
      end
   end

   // Array has no reset; commit is impossible while reset holds the FSM idle,
   // so an aborted write never reaches the array.
   always_ff @(posedge clk) begin
      if (commit && op_wr_q) mem[idx_q] <= wdata_q;
   end

   assign mem_rdata    = rdata_q;
   assign MM_ready     = ready_q;
   assign busy         = busy_q;
   assign protocol_err = perr_q;
   assign rd_count     = rd_cnt_q;
   assign wr_count     = wr_cnt_q;

endmodule
